// File: rtl/clock_period_meter.sv
// Measures the period and high time of an asynchronous periodic signal in clk cycles.
// One measurement per start request; the result is held until the consumer accepts it.
module clock_period_meter #(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 timeout
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        HIGH,
        LOW,
        DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sig_delay;
    logic                   synced;
    logic                   rise;
    logic                   fall;
    logic                   cnt_sat;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_chain <= '0;
            sig_delay  <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], sig_in};
            sig_delay  <= sync_chain[SYNC_STAGES-1];
        end
    end

    assign synced  = sync_chain[SYNC_STAGES-1];
    assign rise    = synced & ~sig_delay;
    assign fall    = ~synced & sig_delay;
    assign cnt_sat = (cnt == CNT_MAX);
    // Saturating increment: an edge seen in the saturation cycle must not wrap the counter.
    assign cnt_inc = cnt_sat ? cnt : cnt + CNT_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            period       <= '0;
            high_time    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ARM;
                        cnt     <= '0;
                        timeout <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                ARM: begin
                    if (rise) begin
                        state <= HIGH;
                        cnt   <= CNT_ONE;
                    end else if (cnt_sat) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                        period       <= CNT_MAX;
                        high_time    <= CNT_MAX;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                HIGH: begin
                    if (fall) begin
                        state     <= LOW;
                        high_time <= cnt;
                        cnt       <= cnt_inc;
                    end else if (cnt_sat) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                        period       <= CNT_MAX;
                        high_time    <= CNT_MAX;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                LOW: begin
                    if (rise) begin
                        state        <= DONE;
                        result_valid <= 1'b1;
                        period       <= cnt;
                    end else if (cnt_sat) begin
                        // high_time was already captured on the falling edge and is kept.
                        state        <= DONE;
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                        period       <= CNT_MAX;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                DONE: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end

                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
